// File: rtl/input_port_ctrl_pkg.sv
// Address helpers for the input port controller, built on the shared io_defs.vh map.
package input_port_ctrl_pkg;
`include "io_defs.vh"

  localparam int unsigned WORD_STRIDE       = `IO_WORD_STRIDE;
  localparam logic [31:0] DEFAULT_BASE_ADDR = `IO_BASE_ADDR;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input int unsigned idx);
    return base + 32'(WORD_STRIDE * idx);
  endfunction

  function automatic logic [31:0] status_addr(input logic [31:0] base, input int unsigned nch);
    return reg_addr(base, `IO_STATUS_INDEX(nch));
  endfunction
endpackage

// File: rtl/input_debounce.sv
// One input channel: 2-flop synchronizer, run-length debounce counter and stable register.
// upd is high in the cycle before the edge on which stable takes the new value.
module input_debounce #(
  parameter int DATA_W       = 5,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] stable,
  output logic              upd
);
  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [DATA_W-1:0] sync1_reg, sync2_reg, prev_reg, stable_reg;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // cnt_next counts further cycles the sample has held after its first one,
  // so reaching CNT_MAX means DEBOUNCE_CYC consecutive identical samples.
  always_comb begin
    cnt_next = '0;
    upd      = 1'b0;
    if (sync2_reg != prev_reg || sync2_reg == stable_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
    upd = (sync2_reg != stable_reg) && (cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      prev_reg   <= '0;
      cnt_reg    <= '0;
      stable_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      cnt_reg   <= cnt_next;
      if (upd) stable_reg <= sync2_reg;
    end
  end

  assign stable = stable_reg;
endmodule

// File: rtl/io_defs.vh
// Shared register-map rules for the memory-mapped input and output control blocks.
// Channel registers sit at BASE + stride*i; the status word follows the last channel.
`ifndef IO_DEFS_VH
`define IO_DEFS_VH

`define IO_BASE_ADDR          32'h000000a0
`define IO_WORD_STRIDE        4
`define IO_STATUS_INDEX(nch)  (nch)

`endif

// File: rtl/input_port_ctrl.sv
// Memory-mapped debounced input port with sticky change flags and clear-on-read status.
// Define INPUT_IRQ_EN to get a registered irq = OR of the change flags; otherwise irq is 0.
module input_port_ctrl
  import input_port_ctrl_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          DATA_W       = 5,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          DEBOUNCE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              addr,
  input  logic                     rd_en,
  input  logic [NUM_CH*DATA_W-1:0] in_raw,
  output logic [31:0]              data_out,
  output logic                     irq
);
  localparam logic [31:0] STATUS_ADDR = status_addr(BASE_ADDR, NUM_CH);

  logic [DATA_W-1:0] stable_arr [NUM_CH];
  logic [NUM_CH-1:0] upd_vec;
  logic [NUM_CH-1:0] flags_reg, flags_next;
  logic              status_rd;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      input_debounce #(
        .DATA_W      (DATA_W),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (in_raw[gi*DATA_W +: DATA_W]),
        .stable(stable_arr[gi]),
        .upd   (upd_vec[gi])
      );
    end
  endgenerate

  // A new update on the same edge as a status-read clear keeps its flag.
  assign status_rd  = rd_en && (addr == STATUS_ADDR);
  assign flags_next = (status_rd ? '0 : flags_reg) | upd_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) flags_reg <= '0;
    else        flags_reg <= flags_next;
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == reg_addr(BASE_ADDR, i)) data_out[DATA_W-1:0] = stable_arr[i];
    end
    if (addr == STATUS_ADDR) data_out[NUM_CH-1:0] = flags_reg;
  end

`ifdef INPUT_IRQ_EN
  logic irq_reg;
  always_ff @(posedge clk) begin
    if (!rst_n) irq_reg <= 1'b0;
    else        irq_reg <= |flags_reg;
  end
  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed self-checking bench for input_port_ctrl: default 2x5-bit instance plus a 4x8-bit instance.
module tb_input_port_ctrl;
`ifdef INPUT_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, addr4;
  logic        rd_en, rd_en4;
  logic [9:0]  in_raw;
  logic [31:0] in_raw4;
  logic [31:0] data_out, data_out4;
  logic        irq, irq4;
  logic        irq_seen = 1'b0;
  int          total = 0;
  int          bad = 0;

  input_port_ctrl dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_en(rd_en),
    .in_raw(in_raw), .data_out(data_out), .irq(irq)
  );

  input_port_ctrl #(.NUM_CH(4), .DATA_W(8)) dut_wide (
    .clk(clk), .rst_n(rst_n), .addr(addr4), .rd_en(rd_en4),
    .in_raw(in_raw4), .data_out(data_out4), .irq(irq4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (irq === 1'b1 || irq4 === 1'b1) irq_seen = 1'b1;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] addrs [4];
    addrs[0] = 32'ha0; addrs[1] = 32'ha4; addrs[2] = 32'ha8; addrs[3] = 32'hac;
    rst_n = 1'b0; rd_en = 1'b0; rd_en4 = 1'b0; in_raw = '0; in_raw4 = '0;
    addr = 32'h0; addr4 = 32'h0;
    tick(2);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      addr = addrs[k]; #1;
      total++;
      if (data_out !== 32'h0) begin
        bad++; $display("FAIL reset_read addr=%h got=%h exp=%h", addr, data_out, 32'h0);
      end else $display("pass reset_read addr=%h data=%h", addr, data_out);
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    else $display("pass reset_irq");
    addr4 = 32'hb0; #1;
    total++;
    if (data_out4 !== 32'h0) begin bad++; $display("FAIL reset_wide_status got=%h exp=0", data_out4); end
    else $display("pass reset_wide_status");
  endtask

  task automatic test_ch0_accept();
    in_raw[4:0] = 5'h15;
    addr = 32'ha0;
    tick(5);
    total++;
    if (data_out !== 32'h0) begin bad++; $display("FAIL ch0_early got=%h exp=%h", data_out, 32'h0); end
    else $display("pass ch0_early data=%h", data_out);
    tick(1);
    total++;
    if (data_out !== 32'h15) begin bad++; $display("FAIL ch0_latency got=%h exp=%h", data_out, 32'h15); end
    else $display("pass ch0_latency data=%h", data_out);
    addr = 32'ha8; #1;
    total++;
    if (data_out !== 32'h1) begin bad++; $display("FAIL ch0_status got=%h exp=%h", data_out, 32'h1); end
    else $display("pass ch0_status data=%h", data_out);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_same_edge got=%b exp=0", irq); end
    else $display("pass irq_same_edge");
    tick(1);
    total++;
    if (irq !== IRQ_EN) begin bad++; $display("FAIL irq_next_cycle got=%b exp=%b", irq, IRQ_EN); end
    else $display("pass irq_next_cycle irq=%b", irq);
  endtask

  task automatic test_ch1_bounce();
    logic [4:0] vals [2];
    vals[0] = 5'h03; vals[1] = 5'h00;
    addr = 32'ha4;
    for (int k = 0; k < 10; k++) begin
      in_raw[9:5] = vals[k % 2];
      tick(2);
    end
    in_raw[9:5] = 5'h00;
    tick(8);
    total++;
    if (data_out !== 32'h0) begin bad++; $display("FAIL bounce_ch1 got=%h exp=%h", data_out, 32'h0); end
    else $display("pass bounce_ch1 data=%h", data_out);
    addr = 32'ha8; #1;
    total++;
    if (data_out !== 32'h1) begin bad++; $display("FAIL bounce_status got=%h exp=%h", data_out, 32'h1); end
    else $display("pass bounce_status data=%h", data_out);
  endtask

  task automatic test_status_clear();
    in_raw[9:5] = 5'h0a;
    tick(6);
    addr = 32'ha4; #1;
    total++;
    if (data_out !== 32'h0a) begin bad++; $display("FAIL ch1_accept got=%h exp=%h", data_out, 32'h0a); end
    else $display("pass ch1_accept data=%h", data_out);
    tick(1);
    addr = 32'ha8; rd_en = 1'b1; #1;
    total++;
    if (data_out !== 32'h3) begin bad++; $display("FAIL clear_preread got=%h exp=%h", data_out, 32'h3); end
    else $display("pass clear_preread data=%h", data_out);
    tick(1);
    rd_en = 1'b0; #1;
    total++;
    if (data_out !== 32'h0) begin bad++; $display("FAIL clear_after got=%h exp=%h", data_out, 32'h0); end
    else $display("pass clear_after data=%h", data_out);
    total++;
    if (irq !== IRQ_EN) begin bad++; $display("FAIL irq_lag got=%b exp=%b", irq, IRQ_EN); end
    else $display("pass irq_lag irq=%b", irq);
    tick(1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
    else $display("pass irq_fall");
    in_raw[9:5] = 5'h0b;
    tick(6);
    total++;
    if (data_out !== 32'h2) begin bad++; $display("FAIL ch1_flag got=%h exp=%h", data_out, 32'h2); end
    else $display("pass ch1_flag data=%h", data_out);
    in_raw[4:0] = 5'h07;
    tick(5);
    rd_en = 1'b1; #1;
    total++;
    if (data_out !== 32'h2) begin bad++; $display("FAIL coincide_preread got=%h exp=%h", data_out, 32'h2); end
    else $display("pass coincide_preread data=%h", data_out);
    tick(1);
    rd_en = 1'b0; #1;
    total++;
    if (data_out !== 32'h1) begin bad++; $display("FAIL set_wins got=%h exp=%h", data_out, 32'h1); end
    else $display("pass set_wins data=%h", data_out);
    addr = 32'ha0; #1;
    total++;
    if (data_out !== 32'h07) begin bad++; $display("FAIL ch0_update got=%h exp=%h", data_out, 32'h07); end
    else $display("pass ch0_update data=%h", data_out);
  endtask

  task automatic test_reset_mid();
    in_raw[4:0] = 5'h1f;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    addr = 32'ha8; #1;
    total++;
    if (data_out !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL midreset_clear status=%h irq=%b exp status=0 irq=0", data_out, irq);
    end else $display("pass midreset_clear");
    addr = 32'ha0;
    tick(5);
    total++;
    if (data_out !== 32'h0) begin bad++; $display("FAIL midreset_early got=%h exp=%h", data_out, 32'h0); end
    else $display("pass midreset_early data=%h", data_out);
    tick(1);
    total++;
    if (data_out !== 32'h1f) begin bad++; $display("FAIL midreset_ch0 got=%h exp=%h", data_out, 32'h1f); end
    else $display("pass midreset_ch0 data=%h", data_out);
    addr = 32'ha4; #1;
    total++;
    if (data_out !== 32'h0b) begin bad++; $display("FAIL midreset_ch1 got=%h exp=%h", data_out, 32'h0b); end
    else $display("pass midreset_ch1 data=%h", data_out);
    addr = 32'ha8; #1;
    total++;
    if (data_out !== 32'h3) begin bad++; $display("FAIL midreset_status got=%h exp=%h", data_out, 32'h3); end
    else $display("pass midreset_status data=%h", data_out);
  endtask

  task automatic test_wide();
    logic [31:0] addrs [4];
    logic [31:0] exps  [4];
    addrs[0] = 32'ha8; exps[0] = 32'hc3;
    addrs[1] = 32'hb0; exps[1] = 32'h4;
    addrs[2] = 32'hb4; exps[2] = 32'h0;
    addrs[3] = 32'ha0; exps[3] = 32'h0;
    in_raw4[23:16] = 8'hc3;
    tick(6);
    for (int k = 0; k < 4; k++) begin
      addr4 = addrs[k]; #1;
      total++;
      if (data_out4 !== exps[k]) begin
        bad++; $display("FAIL wide_read addr=%h got=%h exp=%h", addr4, data_out4, exps[k]);
      end else $display("pass wide_read addr=%h data=%h", addr4, data_out4);
    end
    tick(1);
    total++;
    if (irq4 !== IRQ_EN) begin bad++; $display("FAIL wide_irq got=%b exp=%b", irq4, IRQ_EN); end
    else $display("pass wide_irq irq=%b", irq4);
    tick(1);
    total++;
    if (irq_seen !== IRQ_EN) begin bad++; $display("FAIL irq_activity got=%b exp=%b", irq_seen, IRQ_EN); end
    else $display("pass irq_activity seen=%b", irq_seen);
  endtask

  initial begin
    test_reset();
    test_ch0_accept();
    test_ch1_bounce();
    test_status_clear();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/input_port_ctrl.md
INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of input channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 5, meaning the bits per channel (1..32).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h000000a0, meaning the byte address of channel 0.
REQ-004 SHALL have parameter DEBOUNCE_CYC, default 4, meaning the stable-sample cycles required before accepting a value (>=1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port addr, input, 32 bits: CPU load byte address.
REQ-008 SHALL have port rd_en, input, 1 bit: CPU load strobe, one cycle per access.
REQ-009 SHALL have port in_raw, input, NUM_CH*DATA_W bits: asynchronous switch/button inputs; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port data_out, output, 32 bits: read data.
REQ-011 SHALL have port irq, output, 1 bit: change interrupt request.

Function
REQ-012 SHALL pass each channel through a 2-flop synchronizer before any other use.
REQ-013 SHALL, per channel, hold a debounce counter and a stable register; the counter resets to 0 whenever the synchronized sample differs from the previous cycle's sample.
REQ-014 SHALL, when the sample has differed from stable and has been unchanged for DEBOUNCE_CYC consecutive cycles, load stable with the sample and set that channel's change flag on the same edge.
REQ-015 SHALL hold the counter at 0 while the sample equals stable; the counter SHALL saturate and never wrap.
REQ-016 SHALL drive data_out combinationally as follows: at addr == BASE_ADDR+4*i (i<NUM_CH), stable[i] zero-extended to 32 bits.
REQ-017 SHALL drive data_out at addr == BASE_ADDR+4*NUM_CH (STATUS) as the change flags in bits [NUM_CH-1:0], zero above.
REQ-018 SHALL drive data_out to 32'h0 at any other address.
REQ-019 SHALL clear all change flags on the edge where rd_en=1 and addr==STATUS; the read in that cycle returns the pre-clear value.
REQ-020 SHALL, when a flag set and a status-read clear coincide, leave that flag set (set wins); other flags clear.
REQ-021 SHALL have no side effect when channel registers are read.
REQ-022 SHALL produce latency from an in_raw change to an updated stable value of 2 + DEBOUNCE_CYC cycles.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, clear synchronizers, sample history, counters, stable registers and flags to 0.
REQ-024 SHALL hold irq=0 during and immediately after reset; data_out SHALL read 0 for every address in the cycle after reset.
REQ-025 SHALL discard any pending debounce on reset mid-count; a level held high through reset SHALL be re-accepted after 2+DEBOUNCE_CYC cycles and set its flag.

Configuration
REQ-026 SHALL, with INPUT_IRQ_EN defined, drive irq as a register equal to the OR of all change flags, updated one cycle after the flags change.
REQ-027 SHALL, with INPUT_IRQ_EN undefined, tie irq to constant 0 and generate no irq register; all other behaviour is identical.

Structure
REQ-028 SHALL place BASE_ADDR default, word stride (4) and the STATUS offset rule in the shared header io_defs.vh, used by the output-control block as well.
REQ-029 SHALL implement the synchronizer, counter and stable register as sub-module input_debounce (params DATA_W, DEBOUNCE_CYC; outputs stable and a one-cycle update pulse), instantiated NUM_CH times by generate.

Verification
REQ-030 SHALL cover this directed scenario: reset, then read 0xa0, 0xa4 and 0xa8 -> all 0; irq=0.
REQ-031 SHALL cover this directed scenario: ch0 in_raw=5'h15 held -> 0xa0 reads 0x15 exactly 6 cycles later; status 0xa8 reads 0x1; irq=1 one cycle after the flag (INPUT_IRQ_EN).
REQ-032 SHALL cover this directed scenario: ch1 toggles 5'h03/5'h00 every 2 cycles for 20 cycles, then settles at 0 -> 0xa4 stays 0 and flag bit1 stays 0.
REQ-033 SHALL cover this directed scenario: status read with rd_en=1 -> returns 0x3, next cycle reads 0x0, irq falls; read coinciding with a ch0 update -> next read 0x1.
REQ-034 SHALL cover this directed scenario: rst_n=0 for 1 cycle mid-debounce of ch0=5'h1f -> counter restarts; 0xa0 reads 0x1f 6 cycles after rst_n rises.
REQ-035 SHALL cover this directed scenario: NUM_CH=4, DATA_W=8, read 0xb0 -> status; 0xb4 -> 0; without INPUT_IRQ_EN irq stays 0 throughout.
